cid_sub_seq: RTL and testbench
==============================

// Module: cid_sub_seq
// PURPOSE
//  Sequential borrow-decrement subtractor; the subtract-direction counterpart of the carry-increment adder group.
//  Computes diff = a - b - bin over WIDTH bits, one 4-bit group per clock, LSB group first.
//  Each group forms a raw difference and a decremented copy; the registered group borrow selects between them.
//  Sits beside the carry-increment adder datapath; valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  16  operand width; must be a multiple of GROUP, >= GROUP
//  GROUP   4  bits per group; fixed at 4 to match the half-subtractor group
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operands a, b, bin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow into LSB group
//  out_valid  out  1      diff/bout valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out of MSB group (1 = a < b + bin, unsigned)
//  ovf        out  1      signed overflow; present only with CID_OVF_FLAG_EN
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, group index=0, operand/diff regs=0, borrow reg=0;
//   in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. Reset mid-RUN/DONE aborts; result is discarded.
//  FSM, N = WIDTH/GROUP:
//   IDLE: in_ready=1. in_valid=1 -> latch a, b, bin; idx=0; go RUN.
//   RUN : in_ready=0. Per cycle, group g=idx:
//         raw = a_g - b_g (4-bit, borrow r); dec = raw - 1 through the borrow_dec4 chain (borrow d).
//         diff_g <= borrow_reg ? dec : raw; borrow_reg <= r | (borrow_reg & d).
//         idx==N-1 -> go DONE; otherwise idx++.
//   DONE: out_valid=1, diff/bout stable. out_ready=1 -> IDLE next cycle. in_ready=0 in DONE.
//  Latency: accept edge + N RUN cycles; out_valid rises on the edge after the last RUN cycle (N=4 -> 4 cycles).
//  Throughput: one operation per N+2 cycles at best. No overlap of accept and result.
//  in_valid in RUN/DONE is ignored. Inputs are sampled only at the IDLE accept edge.
//  bout = final borrow_reg. Wrap-around is modulo 2^WIDTH; no saturation.
//  out_valid with out_ready=0: diff/bout/ovf held indefinitely (back-pressure).
// CONFIGURATION
//  `CID_OVF_FLAG_EN defined: ovf port exists.
//   ovf = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]). Registered with DONE; cleared on reset.
//  Not defined: no ovf port, no ovf logic. All other behaviour identical.
// STRUCTURE
//  Shared package cid_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), CID_GROUP=4,
//   and the index-width function clog2(WIDTH/GROUP).
//  Sub-module borrow_dec4: 4 half-subtractors chained from bit 0.
//   Inputs sin[3:0], bprev. Outputs dout[3:0], borrow. This is the mirror of the increment group.
//   The top level instantiates one borrow_dec4 and reuses it every RUN cycle.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x0235, bin=0 -> diff=0x0FFF, bout=0; out_valid 4 cycles after accept.
//  2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1; borrow ripples through all 4 groups.
//  3. a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, bout=0, ovf=1 (macro on).
//  4. Hold out_ready=0 for 10 cycles after out_valid -> diff/bout constant, in_ready=0;
//     out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. rst_n=0 during RUN cycle 2 -> next cycle out_valid=0, in_ready=1, diff=0;
//     a new op (0xFFFF-0xFFFF) -> diff=0x0000, bout=0.
//  6. 1000 random ops with random in_valid/out_ready gaps vs. reference model a-b-bin
//     -> all match, no lost or duplicated results.

Source files
------------

// File: rtl/cid_pkg.sv
// Shared definitions for the carry/borrow-increment group datapaths:
// FSM state encoding, group width and the index-width helper.
package cid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CID_GROUP = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/borrow_dec4.sv
// Four chained half-subtractors: dout = sin - bprev, borrow set when the
// decrement wraps. Mirror image of the increment group in the adder.
module borrow_dec4 (
  input  logic [3:0] sin,
  input  logic       bprev,
  output logic [3:0] dout,
  output logic       borrow
);

  logic [4:0] chain;

  // Each stage borrows onward only if it had to borrow and its bit was 0
  always_comb begin
    chain[0] = bprev;
    for (int i = 0; i < 4; i++) begin
      dout[i]      = sin[i] ^ chain[i];
      chain[i + 1] = ~sin[i] & chain[i];
    end
  end

  assign borrow = chain[4];

endmodule

// File: rtl/cid_sub_seq.sv
// Sequential borrow-decrement subtractor: diff = a - b - bin, one 4-bit group
// per clock, LSB group first. Optional ovf port under `CID_OVF_FLAG_EN.
module cid_sub_seq
  import cid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CID_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CID_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / GROUP;
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic             borrow_reg;
  logic [IW-1:0]    idx;

  logic [GROUP-1:0] a_g, b_g, raw, dec, grp_diff;
  logic             r_borrow, d_borrow, last;

  assign a_g  = a_reg[int'(idx) * GROUP +: GROUP];
  assign b_g  = b_reg[int'(idx) * GROUP +: GROUP];
  assign last = (idx == IW'(N - 1));

  assign {r_borrow, raw} = {1'b0, a_g} - {1'b0, b_g};

  // Single shared decrement group, reused for every group position
  borrow_dec4 u_dec (
    .sin   (raw),
    .bprev (1'b1),
    .dout  (dec),
    .borrow(d_borrow)
  );

  assign grp_diff = borrow_reg ? dec : raw;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // A decremented group only borrows onward when the raw group was zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            idx        <= '0;
          end
        end
        RUN: begin
          diff_reg[int'(idx) * GROUP +: GROUP] <= grp_diff;
          borrow_reg <= r_borrow | (borrow_reg & d_borrow);
          if (!last) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = borrow_reg;

`ifdef CID_OVF_FLAG_EN
  logic ovf_reg;

  // Signed overflow: operands of differing sign and result sign differs from a
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                 (a_reg[WIDTH-1] ^ grp_diff[GROUP-1]);
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_cid_sub_seq.sv
// Directed and randomised self-checking bench for cid_sub_seq (WIDTH=16).
// Checks ovf as well when built with CID_OVF_FLAG_EN.
module tb_cid_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
`ifdef CID_OVF_FLAG_EN
  logic        ovf;
`endif

  int cmp_count;
  int fail_count;

  cid_sub_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef CID_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation, waits for acceptance, then counts edges to out_valid
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic vbin, output int lat);
    int budget;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    bin      = vbin;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      step();
      budget++;
    end
    step();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    step(); step();
    rst_n = 1'b1;
    cmp_count += 4;
    if (in_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    if (diff !== 16'h0000) begin fail_count++; $display("[TB] FAIL reset_diff got %h want 0000", diff); end
    if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_bout got %b want 0", bout); end
`ifdef CID_OVF_FLAG_EN
    cmp_count++;
    if (ovf !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h0235, 1'b0, lat);
    cmp_count += 3;
    if (lat !== 4) begin fail_count++; $display("[TB] FAIL basic_latency got %0d want 4", lat); end
    if (diff !== 16'h0FFF) begin fail_count++; $display("[TB] FAIL basic_diff got %h want 0fff", diff); end
    if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_bout got %b want 0", bout); end
    step();
    cmp_count++;
    if (in_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL basic_idle got %b want 1", in_ready); end
  endtask

  task automatic test_borrow_ripple();
    int lat;
    applyStimulus(16'h0000, 16'h0001, 1'b0, lat);
    cmp_count += 2;
    if (diff !== 16'hFFFF) begin fail_count++; $display("[TB] FAIL ripple_diff got %h want ffff", diff); end
    if (bout !== 1'b1) begin fail_count++; $display("[TB] FAIL ripple_bout got %b want 1", bout); end
    step();
  endtask

  task automatic test_bin_overflow();
    int lat;
    applyStimulus(16'h8000, 16'h0000, 1'b1, lat);
    cmp_count += 2;
    if (diff !== 16'h7FFF) begin fail_count++; $display("[TB] FAIL ovfvec_diff got %h want 7fff", diff); end
    if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL ovfvec_bout got %b want 0", bout); end
`ifdef CID_OVF_FLAG_EN
    cmp_count++;
    if (ovf !== 1'b1) begin fail_count++; $display("[TB] FAIL ovfvec_ovf got %b want 1", ovf); end
`endif
    step();
  endtask

  task automatic test_back_pressure();
    int lat;
    out_ready = 1'b0;
    applyStimulus(16'h5555, 16'h1111, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      cmp_count += 4;
      if (out_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid); end
      if (in_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      if (diff !== 16'h4444) begin fail_count++; $display("[TB] FAIL bp_diff cyc %0d got %h want 4444", i, diff); end
      if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL bp_bout cyc %0d got %b want 0", i, bout); end
      step();
    end
    out_ready = 1'b1;
    step();
    cmp_count += 2;
    if (out_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL bp_release_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    in_valid = 1'b1;
    a = 16'h1111; b = 16'h2222; bin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cmp_count += 4;
    if (out_valid !== 1'b0) begin fail_count++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    if (diff !== 16'h0000) begin fail_count++; $display("[TB] FAIL midrst_diff got %h want 0000", diff); end
    if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL midrst_bout got %b want 0", bout); end
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, lat);
    cmp_count += 3;
    if (out_valid !== 1'b1) begin fail_count++; $display("[TB] FAIL midrst_new_valid got %b want 1", out_valid); end
    if (diff !== 16'h0000) begin fail_count++; $display("[TB] FAIL midrst_new_diff got %h want 0000", diff); end
    if (bout !== 1'b0) begin fail_count++; $display("[TB] FAIL midrst_new_bout got %b want 0", bout); end
    step();
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] expv;
    int          budget;
    int          done_count;
    done_count = 0;
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      expv = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      in_valid = 1'b1;
      a = ra; b = rb; bin = rbin;
      budget = 0;
      while (!in_ready && budget < 20) begin step(); budget++; end
      step();
      budget = 0;
      while (budget < 60) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = 16'($urandom);
        b         = 16'($urandom);
        bin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) break;
        step();
        budget++;
      end
      cmp_count += 2;
      if (!(out_valid && out_ready)) begin
        fail_count++;
        $display("[TB] FAIL rand_timeout op %0d out_valid %b want 1", i, out_valid);
      end else if (diff !== expv[15:0] || bout !== expv[16]) begin
        fail_count++;
        $display("[TB] FAIL rand_result op %0d got %h/%b want %h/%b", i, diff, bout, expv[15:0], expv[16]);
      end else begin
        done_count++;
      end
`ifdef CID_OVF_FLAG_EN
      cmp_count++;
      if (ovf !== ((ra[15] ^ rb[15]) & (ra[15] ^ expv[15]))) begin
        fail_count++;
        $display("[TB] FAIL rand_ovf op %0d got %b", i, ovf);
      end
`endif
      in_valid = 1'b0;
      step();
      if (out_valid !== 1'b0) begin
        fail_count++;
        $display("[TB] FAIL rand_dup op %0d out_valid got %b want 0", i, out_valid);
      end
    end
    out_ready = 1'b1;
    cmp_count++;
    if (done_count !== 1000) begin fail_count++; $display("[TB] FAIL rand_count got %0d want 1000", done_count); end
  endtask

  initial begin
    cmp_count  = 0;
    fail_count = 0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_bin_overflow();
    test_back_pressure();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
